charbuf_writer: RTL and testbench

CHARBUF_WRITER -- requirements
Module: charbuf_writer

---
 rtl/term_pkg.sv | 14 +
 rtl/term_cell_addr.sv | 8 +
 rtl/charbuf_writer.sv | 107 ++++++++++
 tb/tb_charbuf_writer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/term_pkg.sv
// term_pkg: geometry, control codes and FSM states for the 80x60 character buffer writer
package term_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int CELLS = 4800;
  localparam int SCROLL_LAST = 4719;
  localparam int FILL_BASE = 4720;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;
  typedef enum logic [2:0] {CLEAR, IDLE, SCROLL_RD, SCROLL_WR, FILL} state_e;
endpackage

// File: rtl/term_cell_addr.sv
// term_cell_addr: row,col -> 13-bit cell address row*80+col
module term_cell_addr (
  input  logic [5:0]  row,
  input  logic [6:0]  col,
  output logic [12:0] addr
);
  assign addr = ({7'd0, row} << 6) + ({7'd0, row} << 4) + {6'd0, col};
endmodule

// File: rtl/charbuf_writer.sv
// charbuf_writer: byte stream -> 80x60 char buffer writes with cursor, CR/LF/BS/FF, scroll and clear
module charbuf_writer
  import term_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [12:0] buf_ad,
  output logic [7:0]  buf_din,
  output logic        buf_we,
  output logic        buf_ce,
  input  logic [7:0]  buf_dout,
  output logic [6:0]  cur_col,
  output logic [5:0]  cur_row,
  output logic        busy
);
  state_e      state_q, state_d;
  logic [12:0] ptr_q, ptr_d, wr_ad_q, wr_ad_d, cell_ad;
  logic [6:0]  col_q, col_d;
  logic [5:0]  row_q, row_d;
  logic [7:0]  wr_din_q, wr_din_d;
  logic        wr_q, wr_d, quiet_q;
  logic        col_end, row_end;
  term_cell_addr u_addr (.row(row_q), .col(col_q), .addr(cell_ad));
  assign col_end = col_q == 7'(COLS - 1);
  assign row_end = row_q == 6'(ROWS - 1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR;
      ptr_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      wr_q     <= 1'b0;
      wr_ad_q  <= '0;
      wr_din_q <= '0;
      quiet_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      col_q    <= col_d;
      row_q    <= row_d;
      wr_q     <= wr_d;
      wr_ad_q  <= wr_ad_d;
      wr_din_q <= wr_din_d;
      quiet_q  <= 1'b0;
    end
  end
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    col_d    = col_q;
    row_d    = row_q;
    wr_d     = 1'b0;
    wr_ad_d  = wr_ad_q;
    wr_din_d = wr_din_q;
    case (state_q)
      CLEAR: if (!quiet_q) begin
        ptr_d   = ptr_q == 13'(CELLS - 1) ? '0 : ptr_q + 13'd1;
        state_d = ptr_q == 13'(CELLS - 1) ? IDLE : CLEAR;
      end
      IDLE: if (in_valid) begin
        if (in_data >= SPACE && in_data <= 8'h7E) begin
          wr_d     = 1'b1;
          wr_ad_d  = cell_ad;
          wr_din_d = in_data;
          col_d    = col_end ? '0 : col_q + 7'd1;
          row_d    = col_end && !row_end ? row_q + 6'd1 : row_q;
          state_d  = col_end && row_end ? SCROLL_RD : IDLE;
        end else if (in_data == CH_CR) begin
          col_d = '0;
        end else if (in_data == CH_LF) begin
          row_d   = row_end ? row_q : row_q + 6'd1;
          state_d = row_end ? SCROLL_RD : IDLE;
        end else if (in_data == CH_BS) begin
          col_d = col_q == '0 ? col_q : col_q - 7'd1;
        end else if (in_data == CH_FF) begin
          col_d   = '0;
          row_d   = '0;
          state_d = CLEAR;
        end
      end
      // a printable write that triggered the scroll owns the port this cycle
      SCROLL_RD: state_d = wr_q ? SCROLL_RD : SCROLL_WR;
      SCROLL_WR: begin
        ptr_d   = ptr_q == 13'(SCROLL_LAST) ? 13'(FILL_BASE) : ptr_q + 13'd1;
        state_d = ptr_q == 13'(SCROLL_LAST) ? FILL : SCROLL_RD;
      end
      FILL: begin
        ptr_d   = ptr_q == 13'(CELLS - 1) ? '0 : ptr_q + 13'd1;
        state_d = ptr_q == 13'(CELLS - 1) ? IDLE : FILL;
      end
      default: state_d = CLEAR;
    endcase
  end
  always_comb begin
    in_ready = state_q == IDLE;
    busy     = state_q != IDLE;
    buf_ce   = wr_q | (busy & !quiet_q);
    buf_we   = wr_q | ((state_q == CLEAR || state_q == SCROLL_WR || state_q == FILL) & !quiet_q);
    buf_ad   = wr_q ? wr_ad_q : state_q == SCROLL_RD ? ptr_q + 13'(COLS) : ptr_q;
    buf_din  = wr_q ? wr_din_q : state_q == SCROLL_WR ? buf_dout : SPACE;
    cur_col  = col_q;
    cur_row  = row_q;
  end
endmodule

// File: tb/tb_charbuf_writer.sv
// tb_charbuf_writer: scoreboard bench for charbuf_writer with a behavioural buffer RAM
module tb_charbuf_writer;
  typedef struct {logic [12:0] ad; logic [7:0] d;} wr_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, buf_we, buf_ce, busy;
  logic [12:0] buf_ad;
  logic [7:0]  buf_din;
  logic [7:0]  buf_dout = 8'h00;
  logic [6:0]  cur_col;
  logic [5:0]  cur_row;
  logic [7:0]  mem [0:4799];
  logic [7:0]  scr [0:4799];
  wr_t         sb[$];
  wr_t         e;
  int          vectors = 0;
  int          miscompares = 0;
  int          mrow = 0;
  int          mcol = 0;

  charbuf_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .buf_ad(buf_ad), .buf_din(buf_din), .buf_we(buf_we), .buf_ce(buf_ce), .buf_dout(buf_dout),
    .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (buf_ce === 1'b1 && buf_ad < 13'd4800) begin
      if (buf_we === 1'b1) mem[buf_ad] <= buf_din;
      else buf_dout <= mem[buf_ad];
    end
  end

  always @(negedge clk) begin
    if (buf_ce === 1'b1 && buf_ad >= 13'd4800) begin
      miscompares++;
      if (miscompares < 20) $display("FAIL addr_range ad=%0d required <4800", buf_ad);
    end
    if (buf_ce === 1'b1 && buf_we === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        if (miscompares < 20) $display("FAIL unexpected_write ad=%0d din=%h", buf_ad, buf_din);
      end else begin
        e = sb.pop_front();
        if (buf_ad !== e.ad || buf_din !== e.d) begin
          miscompares++;
          if (miscompares < 20)
            $display("FAIL write got %h@%0d required %h@%0d", buf_din, buf_ad, e.d, e.ad);
        end
      end
    end
  end

  function automatic void push(input int a, input logic [7:0] d);
    sb.push_back('{ad: 13'(a), d: d});
  endfunction

  function automatic void push_clear();
    for (int i = 0; i < 4800; i++) begin
      scr[i] = 8'h20;
      push(i, 8'h20);
    end
    mrow = 0;
    mcol = 0;
  endfunction

  function automatic void push_scroll();
    for (int i = 0; i < 4720; i++) begin
      scr[i] = scr[i + 80];
      push(i, scr[i]);
    end
    for (int i = 4720; i < 4800; i++) begin
      scr[i] = 8'h20;
      push(i, 8'h20);
    end
  endfunction

  function automatic void model_apply(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      scr[mrow * 80 + mcol] = b;
      push(mrow * 80 + mcol, b);
      if (mcol == 79) begin
        mcol = 0;
        if (mrow == 59) push_scroll();
        else mrow++;
      end else mcol++;
    end else if (b == 8'h0D) mcol = 0;
    else if (b == 8'h0A) begin
      if (mrow == 59) push_scroll();
      else mrow++;
    end else if (b == 8'h08) begin
      if (mcol > 0) mcol--;
    end else if (b == 8'h0C) push_clear();
  endfunction

  task automatic send(input logic [7:0] b, output int w);
    in_valid = 1'b1;
    in_data = b;
    model_apply(b);
    w = 0;
    while (in_ready !== 1'b1 && w < 20000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20000) begin
      $display("FAIL send_timeout byte=%h in_ready never rose", b);
      $fatal(1);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({busy, buf_we, buf_ce, in_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_outputs busy/we/ce/ready=%b required 1000", {busy, buf_we, buf_ce, in_ready});
    end
    vectors++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_cursor got (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
    sb.delete();
    push_clear();
    reset = 1'b0;
    wait_idle(n);
    vectors++;
    if (n !== 4801) begin
      miscompares++;
      $display("FAIL clear_busy_len got %0d required 4801", n);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL clear_pending got %0d writes left required 0", sb.size());
    end
  endtask

  task automatic test_cr();
    int w;
    send(8'h41, w);
    send(8'h42, w);
    send(8'h0D, w);
    send(8'h43, w);
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (cur_row !== 6'd0 || cur_col !== 7'd1) begin
      miscompares++;
      $display("FAIL cr_cursor got (%0d,%0d) required (0,1)", cur_row, cur_col);
    end
    vectors++;
    if (mem[0] !== 8'h43 || mem[1] !== 8'h42) begin
      miscompares++;
      $display("FAIL cr_cells got %h %h required 43 42", mem[0], mem[1]);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL cr_pending got %0d required 0", sb.size());
    end
  endtask

  task automatic test_wrap();
    int w, tw;
    send(8'h0D, w);
    tw = 0;
    for (int i = 0; i < 82; i++) begin
      send(8'(8'h30 + i % 64), w);
      tw += w;
    end
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (tw !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_stalls got %0d stalls busy=%b required 0 stalls busy=0", tw, busy);
    end
    vectors++;
    if (cur_row !== 6'd1 || cur_col !== 7'd2) begin
      miscompares++;
      $display("FAIL wrap_cursor got (%0d,%0d) required (1,2)", cur_row, cur_col);
    end
    vectors++;
    if (mem[80] !== 8'h40 || mem[81] !== 8'h41) begin
      miscompares++;
      $display("FAIL wrap_cells got %h %h required 40 41", mem[80], mem[81]);
    end
  endtask

  task automatic test_scroll();
    int w, n;
    send(8'h0D, w);
    for (int i = 0; i < 58; i++) send(8'h0A, w);
    send(8'h0A, w);
    in_valid = 1'b0;
    wait_idle(n);
    vectors++;
    if (n !== 9520) begin
      miscompares++;
      $display("FAIL scroll_busy_len got %0d required 9520", n);
    end
    vectors++;
    if (cur_row !== 6'd59 || cur_col !== 7'd0) begin
      miscompares++;
      $display("FAIL scroll_cursor got (%0d,%0d) required (59,0)", cur_row, cur_col);
    end
    vectors++;
    if (mem[0] !== 8'h40 || mem[1] !== 8'h41 || mem[4799] !== 8'h20) begin
      miscompares++;
      $display("FAIL scroll_cells got %h %h %h required 40 41 20", mem[0], mem[1], mem[4799]);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scroll_pending got %0d required 0", sb.size());
    end
  endtask

  task automatic test_print_scroll();
    int w, n;
    for (int i = 0; i < 80; i++) send(8'(8'h61 + i % 26), w);
    in_valid = 1'b0;
    wait_idle(n);
    vectors++;
    if (cur_row !== 6'd59 || cur_col !== 7'd0) begin
      miscompares++;
      $display("FAIL pscroll_cursor got (%0d,%0d) required (59,0)", cur_row, cur_col);
    end
    vectors++;
    if (mem[4640] !== 8'h61 || mem[4719] !== 8'h62) begin
      miscompares++;
      $display("FAIL pscroll_cells got %h %h required 61 62", mem[4640], mem[4719]);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL pscroll_pending got %0d required 0", sb.size());
    end
  endtask

  task automatic test_bs_ff();
    int w;
    send(8'h08, w);
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (cur_row !== 6'd59 || cur_col !== 7'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bs_col0 got (%0d,%0d) busy=%b required (59,0) busy=0", cur_row, cur_col, busy);
    end
    send(8'h58, w);
    send(8'h0C, w);
    send(8'h5A, w);
    vectors++;
    if (w !== 4800) begin
      miscompares++;
      $display("FAIL ff_hold_wait got %0d required 4800", w);
    end
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (cur_row !== 6'd0 || cur_col !== 7'd1 || mem[0] !== 8'h5A) begin
      miscompares++;
      $display("FAIL ff_after got (%0d,%0d) cell0=%h required (0,1) 5a", cur_row, cur_col, mem[0]);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL ff_pending got %0d required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_scroll();
    int w, n;
    for (int i = 0; i < 60; i++) send(8'h0A, w);
    in_valid = 1'b0;
    repeat (3000) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midscroll_busy got %b required 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, buf_we, buf_ce} !== 3'b100) begin
      miscompares++;
      $display("FAIL abort_outputs busy/we/ce=%b required 100", {busy, buf_we, buf_ce});
    end
    vectors++;
    if (cur_row !== 6'd0 || cur_col !== 7'd0) begin
      miscompares++;
      $display("FAIL abort_cursor got (%0d,%0d) required (0,0)", cur_row, cur_col);
    end
    sb.delete();
    push_clear();
    reset = 1'b0;
    wait_idle(n);
    vectors++;
    if (n !== 4801) begin
      miscompares++;
      $display("FAIL abort_clear_len got %0d required 4801", n);
    end
    vectors++;
    if (sb.size() !== 0 || mem[2345] !== 8'h20) begin
      miscompares++;
      $display("FAIL abort_clear got %0d pending cell=%h required 0 pending 20", sb.size(), mem[2345]);
    end
  endtask

  initial begin
    test_reset();
    test_cr();
    test_wrap();
    test_scroll();
    test_print_scroll();
    test_bs_ff();
    test_reset_mid_scroll();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
